demux_tdm4: RTL and testbench

DEMUX_TDM4 -- requirements
Module: demux_tdm4

---
 rtl/demux_tdm4_if.sv | 29 ++
 rtl/demux_tdm4.sv | 103 ++++++++++
 tb/tb_demux_tdm4.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/demux_tdm4_if.sv
// Bus bundle for the 4-slot TDM demultiplexer: slot stream in, frame/status out.
// The master drives the slot stream; the slave (the demux) drives the results.
interface demux_tdm4_if #(
  parameter int unsigned W = 1
);
  logic         en;
  logic         sync;
  logic [W-1:0] din;
  logic [W-1:0] q0;
  logic [W-1:0] q1;
  logic [W-1:0] q2;
  logic [W-1:0] q3;
  logic         frame_valid;
  logic         locked;
  logic         s1;
  logic         s0;
  logic         sync_err;
  logic [7:0]   err_cnt;

  modport master (
    output en, sync, din,
    input  q0, q1, q2, q3, frame_valid, locked, s1, s0, sync_err, err_cnt
  );

  modport slave (
    input  en, sync, din,
    output q0, q1, q2, q3, frame_valid, locked, s1, s0, sync_err, err_cnt
  );
endinterface

// File: rtl/demux_tdm4.sv
// Four-slot TDM demultiplexer with sync-marker framing (HUNT/LOCKED) and error counting.
// Slots 0..2 wait in a shadow buffer; the slot-3 sample commits the whole frame at once.
module demux_tdm4 #(
  parameter int unsigned W = 1
) (
  input logic           clk,
  input logic           rst_n,
  demux_tdm4_if.slave   bus
);

  typedef enum logic [0:0] {StHunt, StLocked} state_e;

  state_e              state_q, state_d;
  logic [1:0]          cnt_q, cnt_d;
  logic [2:0][W-1:0]   shadow_q, shadow_d;
  logic [3:0][W-1:0]   q_q, q_d;
  logic                fv_q, fv_d;
  logic                se_q, se_d;
  logic                locked_q;
  logic [7:0]          err_q, err_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    q_d      = q_q;
    fv_d     = 1'b0;
    se_d     = 1'b0;

    if (bus.en) begin
      case (state_q)
        StHunt: begin
          if (bus.sync) begin
            shadow_d[0] = bus.din;
            cnt_d       = 2'd1;
            state_d     = StLocked;
          end
        end
        StLocked: begin
          if (bus.sync) begin
            // A sync anywhere but slot 0 drops the partial frame and restarts it.
            se_d        = (cnt_q != 2'd0);
            shadow_d[0] = bus.din;
            cnt_d       = 2'd1;
          end else if (cnt_q == 2'd0) begin
            se_d    = 1'b1;
            state_d = StHunt;
          end else begin
            if (cnt_q == 2'd3) begin
              q_d  = {bus.din, shadow_q[2], shadow_q[1], shadow_q[0]};
              fv_d = 1'b1;
            end else if (cnt_q == 2'd1) begin
              shadow_d[1] = bus.din;
            end else begin
              shadow_d[2] = bus.din;
            end
            cnt_d = 2'(cnt_q + 2'd1);
          end
        end
        default: begin
          state_d = StHunt;
          cnt_d   = 2'd0;
        end
      endcase
    end

    err_d = (se_d && (err_q != 8'hff)) ? 8'(err_q + 8'd1) : err_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StHunt;
      cnt_q    <= 2'd0;
      shadow_q <= '0;
      q_q      <= '0;
      fv_q     <= 1'b0;
      se_q     <= 1'b0;
      locked_q <= 1'b0;
      err_q    <= 8'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      q_q      <= q_d;
      fv_q     <= fv_d;
      se_q     <= se_d;
      locked_q <= (state_d == StLocked);
      err_q    <= err_d;
    end
  end

  assign bus.q0          = q_q[0];
  assign bus.q1          = q_q[1];
  assign bus.q2          = q_q[2];
  assign bus.q3          = q_q[3];
  assign bus.frame_valid = fv_q;
  assign bus.sync_err    = se_q;
  assign bus.locked      = locked_q;
  assign bus.s1          = cnt_q[1];
  assign bus.s0          = cnt_q[0];
  assign bus.err_cnt     = err_q;

endmodule

// File: tb/tb_demux_tdm4.sv
// Directed and randomized checks of demux_tdm4 against a frame-level reference model.
module tb_demux_tdm4;
  localparam int unsigned W = 4;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  demux_tdm4_if #(.W(W)) bus ();

  demux_tdm4 #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: position within the frame, or hunting for a sync marker.
  bit           m_locked;
  int           m_slot;
  logic [W-1:0] m_shadow [4];
  logic [W-1:0] m_q [4];
  bit           m_fv;
  bit           m_se;
  int           m_err;

  task automatic model_reset();
    m_locked = 0;
    m_slot   = 0;
    m_fv     = 0;
    m_se     = 0;
    m_err    = 0;
    for (int i = 0; i < 4; i++) begin
      m_shadow[i] = '0;
      m_q[i]      = '0;
    end
  endtask

  task automatic model_step(input logic e, input logic s, input logic [W-1:0] d);
    m_fv = 0;
    m_se = 0;
    if (e) begin
      if (!m_locked) begin
        if (s) begin
          m_shadow[0] = d;
          m_slot      = 1;
          m_locked    = 1;
        end
      end else if (s) begin
        m_se        = (m_slot != 0);
        m_shadow[0] = d;
        m_slot      = 1;
      end else if (m_slot == 0) begin
        m_se     = 1;
        m_locked = 0;
      end else begin
        m_shadow[m_slot] = d;
        if (m_slot == 3) begin
          for (int i = 0; i < 4; i++) m_q[i] = m_shadow[i];
          m_fv = 1;
        end
        m_slot = (m_slot + 1) % 4;
      end
      if (m_se && m_err < 255) m_err++;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("q0", 32'(bus.q0), 32'(m_q[0]));
    chk("q1", 32'(bus.q1), 32'(m_q[1]));
    chk("q2", 32'(bus.q2), 32'(m_q[2]));
    chk("q3", 32'(bus.q3), 32'(m_q[3]));
    chk("frame_valid", 32'(bus.frame_valid), 32'(m_fv));
    chk("sync_err", 32'(bus.sync_err), 32'(m_se));
    chk("locked", 32'(bus.locked), 32'(m_locked));
    chk("slot", 32'({bus.s1, bus.s0}), 32'(m_locked ? m_slot : 0));
    chk("err_cnt", 32'(bus.err_cnt), 32'(m_err));
  endtask

  // Called from a falling edge: drive, let the rising edge sample, check on the next fall.
  task automatic cycle(input logic e, input logic s, input logic [W-1:0] d);
    bus.en   = e;
    bus.sync = s;
    bus.din  = d;
    @(posedge clk);
    model_step(e, s, d);
    @(negedge clk);
    check_all();
  endtask

  task automatic async_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic e;
    logic s;
    checks   = 0;
    errors   = 0;
    bus.en   = 1'b0;
    bus.sync = 1'b0;
    bus.din  = '0;
    rst_n    = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_all();
    rst_n = 1'b1;

    // Basic frame 1,0,1,1.
    cycle(1'b1, 1'b1, 4'h1);
    cycle(1'b1, 1'b0, 4'h0);
    cycle(1'b1, 1'b0, 4'h1);
    cycle(1'b1, 1'b0, 4'h1);
    chk("basic_q", 32'({bus.q0, bus.q1, bus.q2, bus.q3}), 32'h1011);
    chk("basic_fv", 32'(bus.frame_valid), 32'd1);
    chk("basic_locked", 32'(bus.locked), 32'd1);
    cycle(1'b0, 1'b0, 4'h0);
    chk("fv_one_cycle", 32'(bus.frame_valid), 32'd0);

    // en toggling every cycle during a frame.
    cycle(1'b1, 1'b1, 4'h2);
    chk("toggle_slot", 32'({bus.s1, bus.s0}), 32'd1);
    cycle(1'b0, 1'b1, 4'hf);
    chk("slot_frozen", 32'({bus.s1, bus.s0}), 32'd1);
    cycle(1'b1, 1'b0, 4'h5);
    cycle(1'b0, 1'b0, 4'hf);
    cycle(1'b1, 1'b0, 4'h7);
    cycle(1'b0, 1'b1, 4'hf);
    cycle(1'b1, 1'b0, 4'h9);
    chk("toggle_q", 32'({bus.q0, bus.q1, bus.q2, bus.q3}), 32'h2579);
    chk("toggle_fv", 32'(bus.frame_valid), 32'd1);

    // Three back-to-back frames: frame_valid every 4th cycle.
    for (int k = 0; k < 12; k++) begin
      cycle(1'b1, (k % 4) == 0, W'($urandom));
      chk("fv_period", 32'(bus.frame_valid), 32'((k % 4) == 3));
      chk("no_sync_err", 32'(bus.sync_err), 32'd0);
    end

    // Early sync at slot 2, then a fresh frame.
    cycle(1'b1, 1'b1, 4'h3);
    cycle(1'b1, 1'b0, 4'h4);
    cycle(1'b1, 1'b1, 4'ha);
    chk("early_se", 32'(bus.sync_err), 32'd1);
    chk("early_cnt", 32'(bus.err_cnt), 32'd1);
    cycle(1'b1, 1'b0, 4'hb);
    chk("early_se_pulse", 32'(bus.sync_err), 32'd0);
    cycle(1'b1, 1'b0, 4'hc);
    cycle(1'b1, 1'b0, 4'hd);
    chk("early_new_q", 32'({bus.q0, bus.q1, bus.q2, bus.q3}), 32'habcd);

    // Missing sync at slot 0.
    cycle(1'b1, 1'b0, 4'h6);
    chk("miss_se", 32'(bus.sync_err), 32'd1);
    chk("miss_locked", 32'(bus.locked), 32'd0);
    chk("miss_slot", 32'({bus.s1, bus.s0}), 32'd0);
    chk("miss_q_held", 32'({bus.q0, bus.q1, bus.q2, bus.q3}), 32'habcd);

    // Repeated sync while locked violates framing every cycle: saturate the counter.
    for (int i = 0; i < 300; i++) cycle(1'b1, 1'b1, W'($urandom));
    chk("err_sat", 32'(bus.err_cnt), 32'd255);
    cycle(1'b1, 1'b1, 4'h0);
    chk("err_sat_hold", 32'(bus.err_cnt), 32'd255);

    // Complete a frame, then reset between slot 1 and slot 2.
    cycle(1'b1, 1'b0, 4'h8);
    cycle(1'b1, 1'b0, 4'h8);
    cycle(1'b1, 1'b0, 4'h8);
    cycle(1'b1, 1'b1, 4'h1);
    cycle(1'b1, 1'b0, 4'h2);
    async_reset();
    chk("rst_q", 32'({bus.q0, bus.q1, bus.q2, bus.q3}), 32'h0);
    chk("rst_err", 32'(bus.err_cnt), 32'd0);
    cycle(1'b1, 1'b0, 4'h3);
    cycle(1'b1, 1'b0, 4'h4);
    chk("rst_no_fv", 32'(bus.frame_valid), 32'd0);
    chk("rst_hunt", 32'(bus.locked), 32'd0);

    // Randomized traffic, mostly well-framed with occasional violations and resets.
    for (int i = 0; i < 3000; i++) begin
      e = ($urandom % 4) != 0;
      if (!m_locked || m_slot == 0) s = ($urandom % 8) != 0;
      else                          s = ($urandom % 12) == 0;
      if (i % 997 == 500) async_reset();
      cycle(e, s, W'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
